// File: rtl/msm_pkg.sv
// Shared definitions for the Moore state machine block and its stimulus driver.
package msm_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] OP_HOLD     = 2'd0;
  localparam logic [1:0] OP_PULSE_S2 = 2'd1;
  localparam logic [1:0] OP_PULSE_S1 = 2'd2;
  localparam logic [1:0] OP_WAIT_CNT = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/msm_duration_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module msm_duration_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // next count: load wins over decrement, and the count never wraps below zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/msm_stimulus_driver.sv
// Turns HOLD/PULSE/WAIT_CNT commands into timed s1/s2 drive windows for the
// state machine block, closing the loop through its counter output.
module msm_stimulus_driver
  import msm_pkg::*;
#(
  parameter int CNT_W   = msm_pkg::CNT_W,
  parameter int ARG_W   = 5,
  parameter int TIMEOUT = 31
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [ARG_W-1:0] cmd_arg,
  input  logic [CNT_W-1:0] counter_in,
  output logic [1:0]       s1,
  output logic [1:0]       s2,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [7:0]       seg_count
);

  localparam int TMR_W = max_int(ARG_W, $clog2(TIMEOUT + 1));

  state_e             state_d, state_q;
  logic [1:0]         op_d, op_q;
  logic [CNT_W-1:0]   target_d, target_q;
  logic [1:0]         s1_d, s1_q;
  logic [1:0]         s2_d, s2_q;
  logic               busy_d, busy_q;
  logic               done_d, done_q;
  logic               timeout_d, timeout_q;
  logic               cmd_ready_d, cmd_ready_q;
  logic [7:0]         seg_count_d, seg_count_q;

  logic               accept_s;
  logic               tmr_load_s;
  logic               tmr_en_s;
  logic [TMR_W-1:0]   tmr_value_s;
  logic               tmr_expired_s;

  assign accept_s = (state_q == IDLE) && cmd_valid && cmd_ready_q;

  // One timer serves both modes: RUN loads the duration, WAIT loads TIMEOUT-1
  // so that reaching zero lines up with the TIMEOUT-th cycle of the wait.
  msm_duration_timer #(.W(TMR_W)) u_timer (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .load    (tmr_load_s),
    .en      (tmr_en_s),
    .value   (tmr_value_s),
    .expired (tmr_expired_s)
  );

  // next-state, command latch and registered-output values
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    target_d    = target_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_en_s    = 1'b0;
    tmr_value_s = '0;
    s1_d        = 2'd0;
    s2_d        = 2'd0;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d       = cmd_op;
          target_d   = CNT_W'(cmd_arg);
          tmr_load_s = 1'b1;
          if (cmd_op == OP_WAIT_CNT) begin
            tmr_value_s = TMR_W'(TIMEOUT - 1);
            state_d     = WAIT;
          end else begin
            tmr_value_s = TMR_W'(cmd_arg);
            state_d     = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (tmr_expired_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      WAIT: begin
        // a match on the final cycle still counts as a normal completion
        if (counter_in == target_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tmr_expired_s) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == RUN) begin
      case (op_d)
        OP_PULSE_S1: s1_d = 2'd1;
        OP_PULSE_S2: s2_d = 2'd1;
        OP_HOLD:     s1_d = 2'd0;
        default:     s1_d = 2'd0;
      endcase
    end else if (state_d == WAIT) begin
      s1_d = 2'd1;
    end else begin
      s1_d = 2'd0;
    end

    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
    seg_count_d = seg_count_q + 8'(done_d | timeout_d);
  end

  // state and output registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      op_q        <= OP_HOLD;
      target_q    <= '0;
      s1_q        <= 2'd0;
      s2_q        <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      seg_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      target_q    <= target_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      cmd_ready_q <= cmd_ready_d;
      seg_count_q <= seg_count_d;
    end
  end

  assign s1        = s1_q;
  assign s2        = s2_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cmd_ready = cmd_ready_q;
  assign seg_count = seg_count_q;

endmodule
